// File: rtl/rr_onehot_selector_pkg.sv
// Shared types and one-hot helpers for the round-robin selector.
// Helpers work on a fixed maximum width; callers zero-extend and truncate.
package onehot_sel_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int MAX_N     = 32;
  localparam int MAX_IDX_W = 5;

  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] v);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic bit is_onehot(input logic [MAX_N-1:0] v);
    return (v != '0) && ((v & (v - MAX_N'(1))) == '0);
  endfunction

endpackage

// File: rtl/rr_onehot_selector_pick.sv
// Combinational round-robin pick: rotate req so ptr lands at bit 0,
// isolate the lowest set bit, rotate it back into place.
module rr_pick
  import onehot_sel_pkg::*;
#(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     pick_onehot,
  output logic [IDX_W-1:0] pick_idx,
  output logic             any
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] dbl_low;
  logic [N-1:0]   rot;
  logic [N-1:0]   low;

  assign dbl_req     = {req, req} >> ptr;
  assign rot         = dbl_req[N-1:0];
  assign low         = rot & (~rot + N'(1));
  assign dbl_low     = {low, low} << ptr;
  assign pick_onehot = dbl_low[2*N-1:N];
  assign pick_idx    = IDX_W'(onehot_to_idx(MAX_N'(pick_onehot)));
  assign any         = |req;

endmodule

// File: rtl/rr_onehot_selector.sv
// Round-robin arbiter producing a registered one-hot selector with valid/ready.
// Define RR_ONEHOT_BURST_EN to let a requester hold the grant for up to BURST_LEN transfers.
module rr_onehot_selector
  import onehot_sel_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int BURST_LEN = 2,
  localparam int IDX_W     = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [N-1:0]     sel,
  output logic [IDX_W-1:0] sel_idx,
  output logic             burst_last
);

  if (N < 2 || N > MAX_N || BURST_LEN < 1) begin : g_param_check
    $error("rr_onehot_selector: unsupported N or BURST_LEN");
  end

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt, ptr_inc, pick_ptr, idx_nxt, pick_idx;
  logic [N-1:0]     sel_nxt, pick_onehot;
  logic             last_nxt, any, regrant, rotate, load_last, regrant_last;

`ifdef RR_ONEHOT_BURST_EN
  localparam int               CNT_W    = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

  logic [CNT_W-1:0] burst_cnt, cnt_nxt;

  assign regrant      = req[sel_idx] && (burst_cnt < CNT_LAST);
  assign load_last    = (CNT_LAST == '0);
  assign regrant_last = ((burst_cnt + CNT_W'(1)) == CNT_LAST);

  always_comb begin
    cnt_nxt = burst_cnt;
    if (state == GRANT && out_ready) cnt_nxt = regrant ? burst_cnt + CNT_W'(1) : '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) burst_cnt <= '0;
    else        burst_cnt <= cnt_nxt;
  end
`else
  assign regrant      = 1'b0;
  assign load_last    = 1'b1;
  assign regrant_last = 1'b1;
`endif

  // A rotating handshake must arbitrate with the already-advanced pointer.
  assign ptr_inc  = (sel_idx == IDX_W'(N - 1)) ? '0 : sel_idx + IDX_W'(1);
  assign rotate   = (state == GRANT) && out_ready && !regrant;
  assign pick_ptr = rotate ? ptr_inc : ptr;

  rr_pick #(.N(N)) u_pick (
    .req        (req),
    .ptr        (pick_ptr),
    .pick_onehot(pick_onehot),
    .pick_idx   (pick_idx),
    .any        (any)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    idx_nxt   = sel_idx;
    last_nxt  = burst_last;
    unique case (state)
      IDLE: begin
        if (any) begin
          state_nxt = GRANT;
          sel_nxt   = pick_onehot;
          idx_nxt   = pick_idx;
          last_nxt  = load_last;
        end
      end
      GRANT: begin
        if (out_ready) begin
          if (regrant) begin
            last_nxt = regrant_last;
          end else begin
            ptr_nxt = ptr_inc;
            if (any) begin
              sel_nxt  = pick_onehot;
              idx_nxt  = pick_idx;
              last_nxt = load_last;
            end else begin
              state_nxt = IDLE;
              sel_nxt   = '0;
              idx_nxt   = '0;
              last_nxt  = 1'b1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      sel        <= '0;
      sel_idx    <= '0;
      burst_last <= 1'b1;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      sel        <= sel_nxt;
      sel_idx    <= idx_nxt;
      burst_last <= last_nxt;
    end
  end

  assign out_valid = (state == GRANT);

  always_ff @(posedge clock) begin
    if (reset && out_valid) assert (is_onehot(MAX_N'(sel)) && sel[sel_idx]);
  end

endmodule

// File: tb/tb_rr_onehot_selector.sv
// Self-checking bench for rr_onehot_selector against a behavioural arbiter model.
// Build with RR_ONEHOT_BURST_EN to exercise burst mode (BURST_LEN=3).
module tb_rr_onehot_selector;

  localparam int N  = 4;
  localparam int BL = 3;
`ifdef RR_ONEHOT_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [N-1:0] sel;
  logic [1:0]   sel_idx;
  logic         burst_last;

  int total = 0;
  int bad   = 0;

  int m_ptr, m_cnt, m_idx;
  bit m_valid, m_last;

  always #5 clock = ~clock;

  rr_onehot_selector #(.N(N), .BURST_LEN(BL)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .sel       (sel),
    .sel_idx   (sel_idx),
    .burst_last(burst_last)
  );

  // First requester at or after p going round the ring, -1 if none.
  function automatic int pick_fn(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_sel();
    logic [N-1:0] one;
    one = N'(1);
    return m_valid ? (one << m_idx) : '0;
  endfunction

  task automatic model_edge();
    int w;
    if (!reset) begin
      m_valid = 0; m_idx = 0; m_last = 1; m_ptr = 0; m_cnt = 0;
    end else if (!m_valid) begin
      w = pick_fn(req, m_ptr);
      if (w >= 0) begin
        m_valid = 1; m_idx = w; m_cnt = 0; m_last = BURST ? (BL == 1) : 1'b1;
      end
    end else if (out_ready) begin
      if (BURST && req[m_idx] && m_cnt < BL - 1) begin
        m_cnt  = m_cnt + 1;
        m_last = (m_cnt == BL - 1);
      end else begin
        m_ptr = (m_idx + 1) % N;
        m_cnt = 0;
        w = pick_fn(req, m_ptr);
        if (w < 0) begin
          m_valid = 0; m_idx = 0; m_last = 1;
        end else begin
          m_idx = w; m_last = BURST ? (BL == 1) : 1'b1;
        end
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rdy, input logic rst_n);
    reset     = rst_n;
    req       = r;
    out_ready = rdy;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step('0, 1'b1, 1'b1);
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid cyc=%0d got=%b want=0", i, out_valid); end
      total++;
      if (sel !== 4'b0000) begin bad++; $display("FAIL reset_sel cyc=%0d got=%b want=0000", i, sel); end
      total++;
      if (sel_idx !== 2'd0) begin bad++; $display("FAIL reset_idx cyc=%0d got=%0d want=0", i, sel_idx); end
      total++;
      if (burst_last !== 1'b1) begin bad++; $display("FAIL reset_last cyc=%0d got=%b want=1", i, burst_last); end
    end
  endtask

  task automatic test_rotation();
    logic [3:0] exp_sel [4];
    int         exp_idx [4];
`ifdef RR_ONEHOT_BURST_EN
    exp_sel = '{4'b0001, 4'b0001, 4'b0001, 4'b0100};
    exp_idx = '{0, 0, 0, 2};
`else
    exp_sel = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp_idx = '{0, 2, 0, 2};
`endif
    step('0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(4'b0101, 1'b1, 1'b1);
      total++;
      if (sel !== exp_sel[i]) begin bad++; $display("FAIL rotation_sel cyc=%0d got=%b want=%b", i + 1, sel, exp_sel[i]); end
      total++;
      if (sel_idx !== 2'(exp_idx[i])) begin bad++; $display("FAIL rotation_idx cyc=%0d got=%0d want=%0d", i + 1, sel_idx, exp_idx[i]); end
      total++;
      if (sel !== m_sel()) begin bad++; $display("FAIL rotation_model cyc=%0d got=%b want=%b", i + 1, sel, m_sel()); end
    end
  endtask

  task automatic test_backpressure();
    step('0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b1);
    total++;
    if (sel !== 4'b0001 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_first got=%b/%b want=0001/1", sel, out_valid); end
    for (int i = 0; i < 5; i++) begin
      step(4'b1000, 1'b0, 1'b1);
      total++;
      if (sel !== 4'b0001 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc=%0d got=%b/%b want=0001/1", i, sel, out_valid); end
      total++;
      if (sel_idx !== 2'd0) begin bad++; $display("FAIL bp_hold_idx cyc=%0d got=%0d want=0", i, sel_idx); end
    end
    step(4'b1000, 1'b1, 1'b1);
    total++;
    if (sel !== 4'b1000 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_release got=%b/%b want=1000/1", sel, out_valid); end
    total++;
    if (sel !== m_sel()) begin bad++; $display("FAIL bp_model got=%b want=%b", sel, m_sel()); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_sel [3];
`ifdef RR_ONEHOT_BURST_EN
    exp_sel = '{4'b1000, 4'b1000, 4'b0001};
`else
    exp_sel = '{4'b0001, 4'b1000, 4'b0001};
`endif
    step('0, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b1);
    total++;
    if (sel !== 4'b1000) begin bad++; $display("FAIL wrap_first got=%b want=1000", sel); end
    for (int i = 0; i < 3; i++) begin
      step(4'b1001, 1'b1, 1'b1);
      total++;
      if (sel !== exp_sel[i]) begin bad++; $display("FAIL wrap_seq cyc=%0d got=%b want=%b", i, sel, exp_sel[i]); end
      total++;
      if (sel !== m_sel()) begin bad++; $display("FAIL wrap_model cyc=%0d got=%b want=%b", i, sel, m_sel()); end
    end
  endtask

  task automatic test_burst();
    logic [3:0] exp_sel  [7];
    logic       exp_last [7];
`ifdef RR_ONEHOT_BURST_EN
    exp_sel  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    exp_sel  = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
    exp_last = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    step('0, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      step(4'b0011, 1'b1, 1'b1);
      total++;
      if (sel !== exp_sel[i]) begin bad++; $display("FAIL burst_sel grant=%0d got=%b want=%b", i + 1, sel, exp_sel[i]); end
      total++;
      if (burst_last !== exp_last[i]) begin bad++; $display("FAIL burst_last grant=%0d got=%b want=%b", i + 1, burst_last, exp_last[i]); end
      total++;
      if (burst_last !== m_last) begin bad++; $display("FAIL burst_model grant=%0d got=%b want=%b", i + 1, burst_last, m_last); end
    end
  endtask

  task automatic test_reset_mid();
    step('0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b1);
    total++;
    if (sel !== 4'b0100 || out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got=%b/%b want=0100/1", sel, out_valid); end
    step(4'b0100, 1'b0, 1'b0);
    total++;
    if (out_valid !== 1'b0 || sel !== 4'b0000) begin bad++; $display("FAIL midrst_clear got=%b/%b want=0000/0", sel, out_valid); end
    step(4'b1111, 1'b1, 1'b1);
    total++;
    if (sel !== 4'b0001 || sel_idx !== 2'd0) begin bad++; $display("FAIL midrst_first got=%b idx=%0d want=0001 idx=0", sel, sel_idx); end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         rdy, rst_n;
    step('0, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      r     = N'($urandom_range(0, 15));
      rdy   = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 49) != 0);
      step(r, rdy, rst_n);
      total++;
      if (out_valid !== m_valid) begin bad++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", i, out_valid, m_valid); end
      total++;
      if (sel !== m_sel()) begin bad++; $display("FAIL rand_sel cyc=%0d got=%b want=%b", i, sel, m_sel()); end
      total++;
      if (sel_idx !== 2'(m_idx)) begin bad++; $display("FAIL rand_idx cyc=%0d got=%0d want=%0d", i, sel_idx, m_idx); end
      total++;
      if (burst_last !== m_last) begin bad++; $display("FAIL rand_last cyc=%0d got=%b want=%b", i, burst_last, m_last); end
      total++;
      if ($countones(sel) !== (m_valid ? 1 : 0)) begin bad++; $display("FAIL rand_onehot cyc=%0d got=%b want_pop=%0d", i, sel, m_valid ? 1 : 0); end
    end
  endtask

  initial begin
    m_valid = 0; m_idx = 0; m_last = 1; m_ptr = 0; m_cnt = 0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_burst();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_onehot_selector.md
# rr_onehot_selector

Round-robin arbiter that turns a level-sensitive request vector into a registered, strictly one-hot selector word with a valid/ready handshake. It sits directly upstream of the one-hot parameter mux and drives that mux's selector inputs (selectors_0..N-1). It guarantees the downstream OR-reduction never sees zero or multiple hot bits while valid. An optional burst mode lets one requester hold the grant for several consecutive transfers.

## Interface
- N, 4: number of requesters and selector width; N >= 2
- BURST_LEN, 2: max consecutive grants to one requester when burst is compiled in; >= 1
- IDX_W, $clog2(N): width of sel_idx (derived, not overridable)

- clock  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- req  in  N  level requests; bit i = requester i
- out_ready  in  1  downstream accepts current selector
- out_valid  out  1  sel/sel_idx hold a valid grant
- sel  out  N  one-hot grant; all-zero when out_valid=0
- sel_idx  out  IDX_W  binary index of the hot bit in sel
- burst_last  out  1  current grant is the last of its burst; constant 1 when burst is compiled out

## Operation
- States: IDLE (out_valid=0) and GRANT (out_valid=1).
- Arbitration is combinational. Scan req starting at ptr, wrapping modulo N, and pick the first set bit.
- IDLE, any req set: load the pick into sel/sel_idx, go to GRANT. IDLE, req=0: stay in IDLE.
- GRANT, out_ready=0: sel, sel_idx and burst_last are frozen, even if req changes or drops.
- GRANT, out_ready=1 (handshake):
  - Regrant case: burst compiled in, req[sel_idx]=1, and burst_cnt < BURST_LEN-1. Keep the same grant, burst_cnt++, ptr unchanged.
  - Otherwise: ptr <= sel_idx+1 (wraps N-1 -> 0) and burst_cnt <= 0. Load a new pick computed with the updated ptr. If that pick is empty, go to IDLE.
- The winner's own request is eligible again only after all others; a lone requester is re-granted every cycle.
- Invariant: out_valid=1 implies popcount(sel)=1 and sel[sel_idx]=1. out_valid=0 implies sel=0.
- Reset values: out_valid=0, sel=0, sel_idx=0, burst_last=1, ptr=0, burst_cnt=0, state IDLE.

## Timing
- Latency from req to grant is 1 cycle: req sampled at edge t gives out_valid at t+1.
- Back-to-back throughput: 1 grant per cycle while out_ready=1 and any req is set.
- A handshake at edge t presents the next grant after edge t; there is no bubble.
- Reset mid-operation (reset=0 at an edge): all state returns to reset values at that edge, and any pending grant is dropped without a handshake.
- Simultaneous handshake and req change: the next pick uses req as sampled at the same edge.
- Wrap-around: ptr=N-1 with a grant to N-1 sets ptr to 0.

## Configuration
- RR_ONEHOT_BURST_EN defined: burst_cnt register (width $clog2(BURST_LEN)+1) is present and the regrant rule is active. burst_last=1 when burst_cnt==BURST_LEN-1.
- RR_ONEHOT_BURST_EN undefined: no burst_cnt register, BURST_LEN is ignored, every handshake rotates ptr, and burst_last is tied to 1.

## Structure
- Package onehot_sel_pkg holds:
  - state enum {IDLE, GRANT};
  - function onehot_to_idx(N-bit) -> IDX_W;
  - function is_onehot(N-bit) -> bit.
- Sub-module rr_pick, purely combinational: inputs req and ptr; outputs pick_onehot, pick_idx and any. It is implemented as rotate, then lowest-set-bit, then rotate back.
- Top level holds the state, ptr, burst_cnt and output registers.

## Test plan
- Reset/idle, N=4: reset=0 then released, req=4'b0000 -> out_valid=0, sel=4'b0000, sel_idx=0 for 10 cycles.
- Rotation, burst off, out_ready=1:
  - req=4'b0101 from cycle 0;
  - expect sel = 0001, 0100, 0001, 0100 on cycles 1..4;
  - expect sel_idx = 0, 2, 0, 2.
- Backpressure: grant sel=0001 presented, out_ready=0 for 5 cycles, req changed to 4'b1000 -> sel stays 0001 and out_valid stays 1. Then out_ready=1 for one cycle -> next sel=1000.
- Wrap-around:
  - req=4'b1000 for one handshake;
  - then req=4'b1001 with out_ready=1;
  - expect sel = 0001, then 1000, then 0001;
  - ptr goes 0 -> 1 -> 0 (checked via the grant order).
- Burst, RR_ONEHOT_BURST_EN with BURST_LEN=3:
  - req=4'b0011, out_ready=1;
  - expect sel = 0001, 0001, 0001, 0010, 0010, 0010, 0001;
  - burst_last high on the 3rd and 6th grants;
  - without the macro, expect sel alternating 0001/0010.
- Reset mid-op: reset=0 for one edge while out_valid=1 with sel=0100 -> next cycle out_valid=0, sel=0. After release, req=4'b1111 -> first grant sel=0001 (ptr was reset to 0).
